// File: rtl/mips_pkg.sv
// Shared MIPS encodings and hazard-sequencer definitions.
package mips_pkg;

    // Primary opcodes, instruction [31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes, instruction [5:0]
    localparam logic [5:0] FN_JR = 6'h08;

    // Link register written by jal
    localparam logic [4:0] REG_RA = 5'd31;

    // Sequencer state encodings
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_STALL    = 2'd1,
        ST_REDIRECT = 2'd2
    } hz_state_e;

    // A producer destination hits a consumer source; $0 never hits.
    function automatic logic src_match(input logic [4:0] dst,
                                       input logic [4:0] rs,
                                       input logic [4:0] rt,
                                       input logic       rs_used,
                                       input logic       rt_used);
        return (dst != 5'd0) && ((rs_used && (dst == rs)) || (rt_used && (dst == rt)));
    endfunction

endpackage

// File: rtl/instr_reg_use.sv
// Decodes which registers the ID-stage instruction reads and writes.
module instr_reg_use
    import mips_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic        reg_write_i,
    input  logic        id_valid_i,
    output logic [4:0]  dst_o,
    output logic [4:0]  rs_o,
    output logic [4:0]  rt_o,
    output logic        rs_used_o,
    output logic        rt_used_o,
    output logic        is_branch_or_jr_o,
    output logic        is_jump_o
);

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] dst_raw;
    logic       unused_shamt;

    assign op           = instr_i[31:26];
    assign funct        = instr_i[5:0];
    assign rs_o         = instr_i[25:21];
    assign rt_o         = instr_i[20:16];
    assign unused_shamt = ^instr_i[10:6];

    // Classify the opcode into register usage and control-flow kind.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        dst_raw           = instr_i[20:16];
        rs_used_o         = 1'b1;
        rt_used_o         = 1'b0;
        is_branch_or_jr_o = 1'b0;
        is_jump_o         = 1'b0;
        case (op)
            OP_RTYPE: begin
                dst_raw   = instr_i[15:11];
                rt_used_o = 1'b1;
                if (funct == FN_JR) begin
                    is_branch_or_jr_o = 1'b1;
                    is_jump_o         = 1'b1;
                end
            end
            OP_J: begin
                rs_used_o = 1'b0;
                is_jump_o = 1'b1;
            end
            OP_JAL: begin
                dst_raw   = REG_RA;
                rs_used_o = 1'b0;
                is_jump_o = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                rt_used_o         = 1'b1;
                is_branch_or_jr_o = 1'b1;
            end
            OP_BLEZ, OP_BGTZ: is_branch_or_jr_o = 1'b1;
            OP_SB, OP_SH, OP_SW: rt_used_o = 1'b1;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: dst_raw = instr_i[20:16];
            // Unknown opcodes read rs only and never produce a value
            default: dst_raw = 5'd0;
        endcase
        dst_o = (reg_write_i && id_valid_i) ? dst_raw : 5'd0;
    end

endmodule

// File: rtl/hazard_controller.sv
// Load-use and ID-resolved branch hazard sequencer with stall/flush counters.
module hazard_controller
    import mips_pkg::*;
#(
    parameter int DELAY_SLOT = 0,
    parameter int CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [31:0]      Instruction,
    input  logic             IDValid,
    input  logic             RegWrite,
    input  logic             MemRead,
    input  logic             Branch,
    input  logic             BranchTaken,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             IDEXBubble,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam logic FLUSH_ON_REDIRECT = (DELAY_SLOT == 0);

    logic [4:0] id_dst, id_rs, id_rt;
    logic       rs_used, rt_used, is_branch_or_jr, is_jump;

    logic [4:0] ex_dst_q, ex_dst_d, mem_dst_q;
    logic       ex_memread_q, ex_memread_d, mem_memread_q;

    logic       load_use, id_use, stall, redirect;
    hz_state_e  st_q, st_d;

    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    instr_reg_use u_reg_use (
        .instr_i           (Instruction),
        .reg_write_i       (RegWrite),
        .id_valid_i        (IDValid),
        .dst_o             (id_dst),
        .rs_o              (id_rs),
        .rt_o              (id_rt),
        .rs_used_o         (rs_used),
        .rt_used_o         (rt_used),
        .is_branch_or_jr_o (is_branch_or_jr),
        .is_jump_o         (is_jump)
    );

    // Hazard detection against the EX and MEM shadow copies.
    always_comb begin
        load_use = ex_memread_q && src_match(ex_dst_q, id_rs, id_rt, rs_used, rt_used);
        id_use   = is_branch_or_jr &&
                   (src_match(ex_dst_q, id_rs, id_rt, rs_used, rt_used) ||
                    (mem_memread_q && src_match(mem_dst_q, id_rs, id_rt, rs_used, rt_used)));
        stall    = IDValid && (load_use || id_use);
        redirect = !stall && IDValid && ((Branch && BranchTaken) || is_jump);
        // A stalled instruction enters EX as a bubble
        ex_dst_d     = stall ? 5'd0 : id_dst;
        ex_memread_d = !stall && MemRead && IDValid;
    end

    // Shadow pipeline of destination info: ID -> EX -> MEM.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so mem picks up the old ex value.
        if (Rst) begin
            ex_dst_q      <= 5'd0;
            ex_memread_q  <= 1'b0;
            mem_dst_q     <= 5'd0;
            mem_memread_q <= 1'b0;
        end else begin
            ex_dst_q      <= ex_dst_d;
            ex_memread_q  <= ex_memread_d;
            mem_dst_q     <= ex_dst_q;
            mem_memread_q <= ex_memread_q;
        end
    end

    // Sequencer state register.
    always_ff @(posedge Clk) begin
        if (Rst) st_q <= ST_RUN;
        else     st_q <= st_d;
    end

    // Next state and pipeline enables; stall beats redirect, reset beats both.
    always_comb begin
        st_d       = ST_RUN;
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXBubble = 1'b0;
        case (st_q)
            ST_RUN, ST_STALL, ST_REDIRECT: begin
                if (stall)         st_d = ST_STALL;
                else if (redirect) st_d = ST_REDIRECT;
            end
            default: st_d = ST_RUN;
        endcase
        if (stall) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
        end
        if (redirect && FLUSH_ON_REDIRECT) IFIDFlush = 1'b1;
        if (Rst) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IFIDFlush  = 1'b1;
            IDEXBubble = 1'b1;
        end
    end

    // Saturating event counters for stall and flush cycles.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (IFIDFlush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule
